// File: rtl/arith_pipe_pkg.sv
// Shared types and default geometry for the two-stage arithmetic pipeline.
// Mode encoding matches the 2-bit mode field sampled with each operand beat.
package arith_pipe_pkg;

  typedef enum logic [1:0] {
    ModeAdd = 2'b00,
    ModeSub = 2'b01,
    ModeAcc = 2'b10,
    ModeClr = 2'b11
  } mode_e;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefCutW  = 10;
  localparam int unsigned DefAccW  = DefWidth + 8;

  // Modes whose beat rewrites the running accumulator when it enters stage 2.
  function automatic logic mode_touches_acc(mode_e m);
    return (m == ModeAcc) || (m == ModeClr);
  endfunction

endpackage

// File: rtl/arith_pipe_unit_if.sv
// Operand/result handshake bundle for arith_pipe_unit.
// The master side drives operands and consumes results; the unit is the slave.
interface arith_pipe_unit_if
  import arith_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CUT_W = DefCutW,
  parameter int unsigned ACC_W = DefAccW
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [WIDTH-1:0]   op3;
  logic [1:0]         mode;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     res1;
  logic [WIDTH:0]     res2;
  logic [CUT_W-1:0]   cut;
  logic [2*WIDTH-1:0] comb;
  logic [ACC_W-1:0]   acc;

  logic               intr;
  logic               intr_clr;

  modport master (
    output in_valid, op1, op2, op3, mode, out_ready, intr_clr,
    input  in_ready, out_valid, res1, res2, cut, comb, acc, intr
  );

  modport slave (
    input  in_valid, op1, op2, op3, mode, out_ready, intr_clr,
    output in_ready, out_valid, res1, res2, cut, comb, acc, intr
  );

endinterface

// File: rtl/arith_pipe_unit_pipe_stage.sv
// Valid/ready register slice of arbitrary payload width with async active-low reset.
// Ready is combinational from downstream, so a full chain of slices sustains one beat per cycle.
module pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             load;

  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/arith_pipe_unit.sv
// Two-stage arithmetic pipeline: stage 1 captures operands, stage 2 holds results plus
// the accumulator value produced by that beat. Sticky intr flags accumulator wrap-around.
module arith_pipe_unit
  import arith_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CUT_W = DefCutW,
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic              clk,
  input  logic              rst,
  arith_pipe_unit_if.slave  bus
);

  localparam int unsigned ResW = WIDTH + 1;
  localparam int unsigned S1W  = 2 + 3 * WIDTH;
  localparam int unsigned S2W  = 2 * ResW + CUT_W + 2 * WIDTH + ACC_W;

  // Stage 1: raw operands and mode.
  logic [S1W-1:0] s1_in, s1_data;
  logic           s1_valid, s1_ready;

  assign s1_in = {bus.mode, bus.op1, bus.op2, bus.op3};

  pipe_stage #(
    .Width(S1W)
  ) u_stage1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_ready(s1_ready),
    .out_data (s1_data)
  );

  logic [1:0]       s1_mode_raw;
  mode_e            s1_mode;
  logic [WIDTH-1:0] s1_a, s1_b, s1_c;

  assign {s1_mode_raw, s1_a, s1_b, s1_c} = s1_data;
  assign s1_mode = mode_e'(s1_mode_raw);

  // Accumulator state lives outside the slices: it is shared across beats.
  logic [ACC_W-1:0] acc_q, acc_d, acc_upd;
  logic             intr_q, intr_d;
  logic             s1_fire;

  logic [ResW-1:0]  sum_ab, sum_bc, dif_ab, dif_bc;
  logic [ResW-1:0]  res1_c, res2_c;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;

  assign s1_fire = s1_valid && s1_ready;

  always_comb begin
    sum_ab  = {1'b0, s1_a} + {1'b0, s1_b};
    sum_bc  = {1'b0, s1_b} + {1'b0, s1_c};
    dif_ab  = {1'b0, s1_a} - {1'b0, s1_b};
    dif_bc  = {1'b0, s1_b} - {1'b0, s1_c};
    acc_sum = {1'b0, acc_q} + {{(ACC_W - WIDTH){1'b0}}, sum_ab};

    res1_c  = sum_ab;
    res2_c  = sum_bc;
    acc_upd = acc_q;
    acc_ovf = 1'b0;

    unique case (s1_mode)
      ModeAdd: ;
      ModeSub: begin
        res1_c = dif_ab;
        res2_c = dif_bc;
      end
      ModeAcc: begin
        acc_upd = acc_sum[ACC_W-1:0];
        acc_ovf = acc_sum[ACC_W];
      end
      ModeClr: acc_upd = '0;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (s1_fire && mode_touches_acc(s1_mode)) begin
      acc_d = acc_upd;
    end

    // A new overflow wins over a clear arriving on the same edge.
    intr_d = intr_q;
    if (bus.intr_clr) begin
      intr_d = 1'b0;
    end
    if (s1_fire && acc_ovf) begin
      intr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      intr_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      intr_q <= intr_d;
    end
  end

  // Stage 2: everything the beat presents downstream, frozen while stalled.
  logic [S2W-1:0] s2_in, s2_data;

  assign s2_in = {res1_c, res2_c, s1_a[CUT_W-1:0], s1_a, s1_b, acc_upd};

  pipe_stage #(
    .Width(S2W)
  ) u_stage2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s1_ready),
    .in_data  (s2_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (s2_data)
  );

  assign {bus.res1, bus.res2, bus.cut, bus.comb, bus.acc} = s2_data;
  assign bus.intr = intr_q;

endmodule

// File: tb/tb_arith_pipe_unit.sv
// Bench for arith_pipe_unit: vector table, directed multi-cycle corner sequences and
// randomized traffic scored against a transaction-level arithmetic model.
module tb_arith_pipe_unit;
  import arith_pipe_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 10;
  localparam int unsigned AW = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  arith_pipe_unit_if #(.WIDTH(W), .CUT_W(CW), .ACC_W(AW)) bus ();

  arith_pipe_unit #(.WIDTH(W), .CUT_W(CW), .ACC_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [32:0] res1;
    logic [32:0] res2;
    logic [9:0]  cut;
    logic [63:0] comb;
    logic [39:0] acc;
  } exp_t;

  typedef struct {
    mode_e       mode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  exp_t            sbq[$];
  logic [39:0]     got_acc[$];
  longint unsigned m_acc;
  bit              m_ovf;
  bit              sb_on;
  bit              log_en;
  int              n_accepted;
  logic [39:0]     last_acc;
  vec_t            tbl[8];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Arithmetic rules evaluated with 64-bit integers, in acceptance order.
  function automatic exp_t model(logic [1:0] mode, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] c);
    longint unsigned x = a, y = b, z = c;
    longint unsigned m33 = (64'd1 << 33) - 1;
    longint unsigned a40 = 64'd1 << 40;
    exp_t e;
    if (mode == ModeSub) begin
      e.res1 = 33'((x - y) & m33);
      e.res2 = 33'((y - z) & m33);
    end else begin
      e.res1 = 33'(x + y);
      e.res2 = 33'(y + z);
    end
    if (mode == ModeAcc) begin
      m_acc = m_acc + x + y;
      if (m_acc >= a40) begin
        m_acc = m_acc - a40;
        m_ovf = 1'b1;
      end
    end else if (mode == ModeClr) begin
      m_acc = 0;
    end
    e.cut  = a[9:0];
    e.comb = {a, b};
    e.acc  = 40'(m_acc);
    return e;
  endfunction

  task automatic sb_eval();
    int n = sbq.size();
    bit acc_in, fire;
    exp_t e;
    chk("in_ready", bus.in_ready, (n < 2) || bus.out_ready);
    if (bus.out_valid) begin
      if (n == 0) begin
        chk("spurious_out_valid", bus.out_valid, 0);
      end else begin
        chk("sb_res1", bus.res1, sbq[0].res1);
        chk("sb_res2", bus.res2, sbq[0].res2);
        chk("sb_cut", bus.cut, sbq[0].cut);
        chk("sb_comb", bus.comb, sbq[0].comb);
        chk("sb_acc", bus.acc, sbq[0].acc);
      end
    end
    acc_in = bus.in_valid && bus.in_ready;
    fire   = bus.out_valid && bus.out_ready;
    if (fire && n > 0) begin
      last_acc = bus.acc;
      if (log_en) got_acc.push_back(bus.acc);
      void'(sbq.pop_front());
    end
    if (acc_in) begin
      e = model(bus.mode, bus.op1, bus.op2, bus.op3);
      sbq.push_back(e);
      n_accepted++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (sb_on) sb_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.op3       = '0;
    bus.mode      = ModeAdd;
    bus.out_ready = 1'b1;
    bus.intr_clr  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sbq.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pump(int n, logic [1:0] mode, logic [31:0] a, logic [31:0] b);
    int start = n_accepted;
    bit done = 1'b0;
    bus.mode      = mode;
    bus.op1       = a;
    bus.op2       = b;
    bus.op3       = '0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < n + 50; cyc++) begin
      bus.in_valid = (n_accepted - start < n);
      if (n_accepted - start >= n && sbq.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pump_done", done, 1);
  endtask

  task automatic fill_to_edge();
    pump(1, ModeClr, 32'h1, 32'h2);
    pump(128, ModeAcc, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("fill_acc", last_acc, 40'hFF_FFFF_FF00);
  endtask

  task automatic ovf_beat(bit with_clr);
    bus.mode      = ModeAcc;
    bus.op1       = 32'h100;
    bus.op2       = 32'h5;
    bus.op3       = '0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.intr_clr = with_clr;
    tick();
    bus.intr_clr = 1'b0;
    chk("ovf_intr", bus.intr, 1);
    chk("ovf_acc", bus.acc, 40'h5);
    chk("ovf_out_valid", bus.out_valid, 1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{ModeAdd, 32'hFFFF_FFFF, 32'h1, 32'h2,
               '{33'h1_0000_0000, 33'h3, 10'h3FF, 64'hFFFF_FFFF_0000_0001, 40'h0}};
    tbl[1] = '{ModeSub, 32'h5, 32'h7, 32'h7,
               '{33'h1_FFFF_FFFE, 33'h0, 10'h5, 64'h0000_0005_0000_0007, 40'h0}};
    tbl[2] = '{ModeAcc, 32'h10, 32'h20, 32'h0,
               '{33'h30, 33'h20, 10'h10, 64'h0000_0010_0000_0020, 40'h30}};
    tbl[3] = '{ModeAdd, 32'h400, 32'h0, 32'hFFFF_FFFF,
               '{33'h400, 33'h0_FFFF_FFFF, 10'h0, 64'h0000_0400_0000_0000, 40'h30}};
    tbl[4] = '{ModeSub, 32'h0, 32'h1, 32'h0,
               '{33'h1_FFFF_FFFF, 33'h1, 10'h0, 64'h0000_0000_0000_0001, 40'h30}};
    tbl[5] = '{ModeAcc, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
               '{33'h1_FFFF_FFFE, 33'h0_FFFF_FFFF, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF,
                 40'h2_0000_002E}};
    tbl[6] = '{ModeClr, 32'h1, 32'h2, 32'h3,
               '{33'h3, 33'h5, 10'h1, 64'h0000_0001_0000_0002, 40'h0}};
    tbl[7] = '{ModeSub, 32'h7, 32'h5, 32'h10,
               '{33'h2, 33'h1_FFFF_FFF5, 10'h7, 64'h0000_0007_0000_0005, 40'h0}};

    idle_inputs();
    sb_on      = 1'b0;
    log_en     = 1'b0;
    n_accepted = 0;
    m_acc      = 0;
    m_ovf      = 1'b0;
    last_acc   = '0;

    // Reset state while held low.
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_intr", bus.intr, 0);
    chk("rst_res1", bus.res1, 0);
    chk("rst_res2", bus.res2, 0);
    chk("rst_cut", bus.cut, 0);
    chk("rst_comb", bus.comb, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: one isolated beat each, two-edge latency, running accumulator.
    for (int i = 0; i < 8; i++) begin
      bus.mode      = tbl[i].mode;
      bus.op1       = tbl[i].op1;
      bus.op2       = tbl[i].op2;
      bus.op3       = tbl[i].op3;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      chk("tbl_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_lat1_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("tbl_out_valid", bus.out_valid, 1);
      chk("tbl_res1", bus.res1, tbl[i].e.res1);
      chk("tbl_res2", bus.res2, tbl[i].e.res2);
      chk("tbl_cut", bus.cut, tbl[i].e.cut);
      chk("tbl_comb", bus.comb, tbl[i].e.comb);
      chk("tbl_acc", bus.acc, tbl[i].e.acc);
      @(posedge clk);
      #1;
    end
    chk("tbl_intr", bus.intr, 0);

    // Eight back-to-back ACC beats against a toggling out_ready.
    do_reset();
    sb_on  = 1'b1;
    log_en = 1'b1;
    got_acc.delete();
    begin
      int start = n_accepted;
      bus.mode = ModeAcc;
      bus.op1  = 32'h10;
      bus.op2  = 32'h10;
      bus.op3  = 32'h0;
      for (int cyc = 0; cyc < 100; cyc++) begin
        bus.out_ready = (cyc % 2 == 0);
        bus.in_valid  = (n_accepted - start < 8);
        if (n_accepted - start >= 8 && sbq.size() == 0) break;
        tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    log_en = 1'b0;
    chk("b2b_count", got_acc.size(), 8);
    for (int k = 0; k < 8 && k < got_acc.size(); k++) begin
      chk("b2b_acc", got_acc[k], 40'(32 * (k + 1)));
    end

    // Accumulator wrap, sticky intr, explicit clear, then clear colliding with overflow.
    fill_to_edge();
    chk("pre_ovf_intr", bus.intr, 0);
    ovf_beat(1'b0);
    repeat (3) tick();
    chk("intr_sticky", bus.intr, 1);
    bus.intr_clr = 1'b1;
    tick();
    bus.intr_clr = 1'b0;
    chk("intr_cleared", bus.intr, 0);
    fill_to_edge();
    chk("intr_quiet", bus.intr, 0);
    ovf_beat(1'b1);

    // Reset with two beats in flight, then first-beat latency after release.
    sb_on         = 1'b0;
    bus.mode      = ModeAcc;
    bus.op1       = 32'h10;
    bus.op2       = 32'h10;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    tick();
    chk("midrst_pre_out_valid", bus.out_valid, 1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_acc", bus.acc, 0);
    chk("midrst_intr", bus.intr, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_res1", bus.res1, 0);
    sbq.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", bus.out_valid, 0);
    bus.mode     = ModeAdd;
    bus.op1      = 32'h3;
    bus.op2      = 32'h4;
    bus.op3      = 32'h5;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lat1", bus.out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_lat2", bus.out_valid, 1);
    chk("post_rst_res1", bus.res1, 33'h7);
    chk("post_rst_res2", bus.res2, 33'h9);
    chk("post_rst_acc", bus.acc, 40'h0);
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    do_reset();
    sb_on = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.mode      = 2'($urandom_range(0, 3));
      bus.op1       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      bus.op2       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      bus.op3       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.intr_clr  = 1'b0;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && sbq.size() != 0; cyc++) tick();
    chk("rand_drain", sbq.size(), 0);
    chk("rand_intr", bus.intr, m_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
